// File: rtl/xbus_fifo_slave.sv
// xbus_fifo_slave
//   Responder on the 8051 XDATA bus for a 4-register window at BASE_ADDR.
//   The 2-cycle memrd/memwr level strobes become single-cycle actions.
//   The window gives byte access to an RX FIFO (filled by the peripheral) and
//   a TX FIFO (drained by the peripheral), plus status, control and an irq.
//
//   Register window, selected by mem_addr[1:0]:
//     0 DATA   : read pops the RX head, write pushes into the TX FIFO
//     1 STATUS : {2'b0, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty}
//                writing 1 to bit 4 or bit 5 clears that sticky flag
//     2 CTRL   : bit0 rx_irq_en, bit1 tx_irq_en; writing bit7=1 flushes both FIFOs
//     3 RXCNT  : RX occupancy (read-only)
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   mem_addr/mem_wdata        XDATA address and write data
//   memwr/memrd               XDATA write/read strobes (2-cycle level pulses)
//   mem_rdata                 registered read data
//   rx_push/rx_din/rx_full    peripheral side of the RX FIFO
//   tx_pop/tx_dout/tx_empty   peripheral side of the TX FIFO
//   irq                       level interrupt to the 8051
module xbus_fifo_slave #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'hF000,
  parameter int                DEPTH     = 16,
  parameter int                PTR_W     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  input  logic              memwr,
  input  logic              memrd,
  output logic [7:0]        mem_rdata,
  input  logic              rx_push,
  input  logic [7:0]        rx_din,
  output logic              rx_full,
  input  logic              tx_pop,
  output logic [7:0]        tx_dout,
  output logic              tx_empty,
  output logic              irq
);

  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;

  logic             memrd_p1, memwr_p1, post_rst_blk;
  logic             cs, rd_fire, wr_fire;
  logic [1:0]       reg_sel;
  logic             flush;

  logic [7:0]       rx_mem [DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] rx_cnt;
  logic             rx_empty, rx_wr, rx_rd, rx_ovf, rx_ovf_set, rx_ovf_clr;

  logic [7:0]       tx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0] tx_cnt;
  logic             tx_full, tx_wr, tx_rd, tx_ovf, tx_ovf_set, tx_ovf_clr;

  logic             rx_irq_en, tx_irq_en;
  logic [7:0]       status_byte, rxcnt_byte, rd_mux;
  logic [8:0]       rx_cnt9;
  logic             unused_wdata;

  assign unused_wdata = ^{mem_wdata[6], mem_wdata[3:2]};

  // ---- stage p1: registered strobes for edge detection ----
  // post_rst_blk suppresses the first cycle after reset so a strobe that was
  // already high when reset released is treated as stale.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      memrd_p1     <= 1'b0;
      memwr_p1     <= 1'b0;
      post_rst_blk <= 1'b1;
    end else begin
      memrd_p1     <= memrd;
      memwr_p1     <= memwr;
      post_rst_blk <= 1'b0;
    end
  end

  assign cs      = (mem_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign reg_sel = mem_addr[1:0];
  assign rd_fire = cs & memrd & ~memrd_p1 & ~post_rst_blk;
  assign wr_fire = cs & memwr & ~memwr_p1 & ~post_rst_blk;
  assign flush   = wr_fire & (reg_sel == REG_CTRL) & mem_wdata[7];

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);

  // A pop frees a slot in the same cycle, so push-while-full succeeds when paired.
  assign rx_rd      = rd_fire & (reg_sel == REG_DATA) & ~rx_empty & ~flush;
  assign rx_wr      = rx_push & ~flush & (~rx_full | rx_rd);
  assign rx_ovf_set = rx_push & ~flush & rx_full & ~rx_rd;
  assign rx_ovf_clr = wr_fire & (reg_sel == REG_STAT) & mem_wdata[4];

  assign tx_rd      = tx_pop & ~tx_empty & ~flush;
  assign tx_wr      = wr_fire & (reg_sel == REG_DATA) & (~tx_full | tx_rd);
  assign tx_ovf_set = wr_fire & (reg_sel == REG_DATA) & tx_full & ~tx_rd;
  assign tx_ovf_clr = wr_fire & (reg_sel == REG_STAT) & mem_wdata[5];

  assign tx_dout = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

  // ---- stage p2: FIFO state, flags, control, read data, irq ----
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else if (flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (rx_wr) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_rd) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_wr, rx_rd})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (tx_wr) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_rd) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_wr, tx_rd})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rx_wr) rx_mem[rx_wr_ptr] <= rx_din;
    if (tx_wr) tx_mem[tx_wr_ptr] <= mem_wdata;
  end

  // Set wins over a simultaneous clear so no overflow event is lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      irq       <= 1'b0;
    end else begin
      rx_ovf <= rx_ovf_set | (rx_ovf & ~rx_ovf_clr);
      tx_ovf <= tx_ovf_set | (tx_ovf & ~tx_ovf_clr);
      if (wr_fire && reg_sel == REG_CTRL) begin
        rx_irq_en <= mem_wdata[0];
        tx_irq_en <= mem_wdata[1];
      end
      irq <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty) | rx_ovf | tx_ovf;
    end
  end

  assign status_byte = {2'b00, tx_ovf, rx_ovf, tx_full, tx_empty, rx_full, rx_empty};
  // Count is PTR_W+1 bits; with DEPTH=256 it needs 9 bits and saturates.
  assign rx_cnt9     = 9'(rx_cnt);
  assign rxcnt_byte  = rx_cnt9[8] ? 8'hFF : rx_cnt9[7:0];

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      REG_DATA: rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      REG_STAT: rd_mux = status_byte;
      REG_CTRL: rd_mux = {6'b0, tx_irq_en, rx_irq_en};
      REG_CNT:  rd_mux = rxcnt_byte;
      default:  rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mem_rdata <= 8'h00;
    end else if (rd_fire) begin
      mem_rdata <= rd_mux;
    end
  end

endmodule
